// File: rtl/prio_enc_q.sv
// prio_enc_q - registered priority encoder with event capture and valid/ready output.
//
// Request pulses on d_in are latched into a pending vector. One pending index at a
// time is presented on d_out (valid/ready handshake) and held until accepted. The
// winner is picked by a fixed-LSB, fixed-MSB or round-robin select. Several requests
// are serialised one grant per cycle. When no request is pending, no output is produced.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   d_in       [N-1:0] request event lines, sampled every cycle
//   clr        synchronous flush of pending/valid/overflow, round-robin pointer reset
//   out_ready  consumer accepts d_out this cycle
//   d_out      [W-1:0] encoded index of current grant (always < N)
//   out_valid  d_out is valid
//   pending    [N-1:0] registered pending-request vector
//   multi      more than one request pending
//   overflow   one-cycle pulse: a request hit an index that was already pending
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no grant presented, out_valid=0
// ST_HOLD | d_out holds a grant, out_valid=1, waiting for out_ready
module prio_enc_q #(
   parameter int N    = 8,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d_in,
   input  logic         clr,
   input  logic         out_ready,
   output logic [W-1:0] d_out,
   output logic         out_valid,
   output logic [N-1:0] pending,
   output logic         multi,
   output logic         overflow
);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W-1:0]   d_out_q, d_out_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic           overflow_q, overflow_d;

   logic           acc;
   logic [N-1:0]   acc_vec;
   logic [N-1:0]   rem;

   // Select one set index of v. base is the round-robin pointer: the search begins
   // at base+1 and wraps modulo N, so a non-power-of-two N never yields index >= N.
   function automatic logic [W-1:0] sel_fn(input logic [N-1:0] v, input logic [W-1:0] base);
      logic [W-1:0] idx;
      logic         found;
      int           j;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      if (MODE == 1) begin
         for (int i = 0; i < N; i++) begin
            if (v[i]) idx = W'(i);
         end
      end else if (MODE == 2) begin
         for (int k = 1; k <= N; k++) begin
            j = int'(base) + k;
            if (j >= N) j = j - N;
            if (!found && v[j]) begin
               idx   = W'(j);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
         end
      end
      return idx;
   endfunction

   assign out_valid = (state_q == ST_HOLD);
   assign acc       = out_valid & out_ready;

   always_comb begin
      acc_vec = '0;
      for (int i = 0; i < N; i++) begin
         acc_vec[i] = acc && (d_out_q == W'(i));
      end
   end

   assign rem = pending_q & ~acc_vec;

   always_comb begin
      state_d    = state_q;
      d_out_d    = d_out_q;
      ptr_d      = ptr_q;
      pending_d  = pending_q;
      overflow_d = 1'b0;
      if (clr) begin
         state_d   = ST_IDLE;
         pending_d = '0;
         ptr_d     = W'(N - 1);
      end else begin
         // A d_in bit in the accept cycle re-sets the bit being cleared.
         pending_d  = rem | d_in;
         overflow_d = |(d_in & pending_q & ~acc_vec);
         if (acc) ptr_d = d_out_q;
         case (state_q)
            ST_IDLE: begin
               if (|pending_q) begin
                  d_out_d = sel_fn(pending_q, ptr_q);
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (acc) begin
                  // Search from the index just granted so round-robin advances.
                  if (|rem) d_out_d = sel_fn(rem, d_out_q);
                  else      state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         d_out_q    <= '0;
         ptr_q      <= W'(N - 1);
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         d_out_q    <= d_out_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign d_out    = d_out_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   // Nonzero after clearing the lowest set bit means at least two bits are set.
   assign multi    = |(pending_q & (pending_q - N'(1)));

endmodule

// File: tb/tb_prio_enc_q.sv
module tb_prio_enc_q;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   logic out_ready;

   logic [7:0] din0, din1, din2;
   logic [4:0] din3;
   logic [2:0] dout0, dout1, dout2, dout3;
   logic       vld0, vld1, vld2, vld3;
   logic [7:0] pnd0, pnd1, pnd2;
   logic [4:0] pnd3;
   logic       mul0, mul1, mul2, mul3;
   logic       ovf0, ovf1, ovf2, ovf3;

   int total = 0;
   int bad   = 0;
   int act   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   prio_enc_q #(.N(8), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .d_in(din0), .clr(clr),
      .out_ready(out_ready), .d_out(dout0), .out_valid(vld0), .pending(pnd0), .multi(mul0), .overflow(ovf0));
   prio_enc_q #(.N(8), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .d_in(din1), .clr(clr),
      .out_ready(out_ready), .d_out(dout1), .out_valid(vld1), .pending(pnd1), .multi(mul1), .overflow(ovf1));
   prio_enc_q #(.N(8), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .d_in(din2), .clr(clr),
      .out_ready(out_ready), .d_out(dout2), .out_valid(vld2), .pending(pnd2), .multi(mul2), .overflow(ovf2));
   prio_enc_q #(.N(5), .MODE(2)) u3 (.clk(clk), .rst_n(rst_n), .d_in(din3), .clr(clr),
      .out_ready(out_ready), .d_out(dout3), .out_valid(vld3), .pending(pnd3), .multi(mul3), .overflow(ovf3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: a grant leaves the DUT when valid&ready at the coming edge.
   task automatic tick();
      logic       v;
      logic [2:0] d;
      int         e;
      case (act)
         0:       begin v = vld0; d = dout0; end
         1:       begin v = vld1; d = dout1; end
         2:       begin v = vld2; d = dout2; end
         default: begin v = vld3; d = dout3; end
      endcase
      if (v && out_ready && !clr) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL sb_unexpected: observed=%0d expected=none", d);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_grant", 32'(d), 32'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
      tick(); tick();
      chk("rst_valid", 32'(vld0), 0);
      chk("rst_dout", 32'(dout0), 0);
      chk("rst_pending", 32'(pnd0), 0);
      chk("rst_overflow", 32'(ovf0), 0);
      chk("rst_multi", 32'(mul0), 0);
      rst_n = 1'b1;
      tick();

      // single request, MODE 0
      act = 0;
      din0 = 8'h10; exp_q.push_back(4);
      tick(); din0 = '0;
      chk("single_pend", 32'(pnd0), 32'h10);
      chk("single_valid_t1", 32'(vld0), 0);
      tick();
      chk("single_valid_t2", 32'(vld0), 1);
      chk("single_dout", 32'(dout0), 4);
      tick();
      chk("single_valid_after", 32'(vld0), 0);
      chk("single_pend_after", 32'(pnd0), 0);
      chk("single_sb_empty", 32'(exp_q.size()), 0);

      // multi-hot, MODE 0
      din0 = 8'h85; exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(7);
      tick(); din0 = '0;
      chk("multi_pend", 32'(pnd0), 32'h85);
      chk("multi_flag0", 32'(mul0), 1);
      tick();
      chk("multi_d0", 32'(dout0), 0);
      tick();
      chk("multi_d2", 32'(dout0), 2);
      chk("multi_pend2", 32'(pnd0), 32'h84);
      chk("multi_flag2", 32'(mul0), 1);
      tick();
      chk("multi_d7", 32'(dout0), 7);
      chk("multi_flag7", 32'(mul0), 0);
      tick();
      chk("multi_done", 32'(vld0), 0);
      chk("multi_sb_empty", 32'(exp_q.size()), 0);

      // backpressure, MODE 1
      act = 1;
      out_ready = 1'b0; din1 = 8'h42;
      tick(); din1 = '0;
      tick();
      chk("bp_valid", 32'(vld1), 1);
      chk("bp_dout", 32'(dout1), 6);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_hold", 32'(dout1), 6);
         chk("bp_hold_valid", 32'(vld1), 1);
      end
      chk("bp_ovf_before", 32'(ovf1), 0);
      din1 = 8'h40;
      tick(); din1 = '0;
      chk("bp_ovf_pulse", 32'(ovf1), 1);
      chk("bp_dout_ovf", 32'(dout1), 6);
      tick();
      chk("bp_ovf_end", 32'(ovf1), 0);
      exp_q.push_back(6); exp_q.push_back(1);
      out_ready = 1'b1;
      tick();
      chk("bp_d1", 32'(dout1), 1);
      tick();
      chk("bp_done", 32'(vld1), 0);
      chk("bp_sb_empty", 32'(exp_q.size()), 0);

      // round-robin, MODE 2, all requests held
      act = 2;
      din2 = 8'hFF;
      for (int i = 0; i < 10; i++) exp_q.push_back(i % 8);
      tick();
      chk("rr_ovf_first", 32'(ovf2), 0);
      chk("rr_valid_t1", 32'(vld2), 0);
      tick();
      chk("rr_valid", 32'(vld2), 1);
      chk("rr_ovf_t2", 32'(ovf2), 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rr_ovf", 32'(ovf2), 1);
      end
      chk("rr_sb_empty", 32'(exp_q.size()), 0);
      out_ready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0; din2 = '0; out_ready = 1'b1;
      chk("rr_clr_valid", 32'(vld2), 0);
      chk("rr_clr_pend", 32'(pnd2), 0);
      chk("rr_clr_ovf", 32'(ovf2), 0);

      // N=5 round-robin with flush
      act = 3;
      din3 = 5'b10001; exp_q.push_back(0); exp_q.push_back(4);
      tick(); din3 = '0;
      tick();
      chk("n5_d0", 32'(dout3), 0);
      tick();
      chk("n5_d4", 32'(dout3), 4);
      tick();
      chk("n5_idle", 32'(vld3), 0);
      din3 = 5'b11111; exp_q.push_back(0); exp_q.push_back(1);
      tick();
      tick();
      chk("n5_all_d0", 32'(dout3), 0);
      chk("n5_range0", 32'(dout3 <= 3'd4), 1);
      tick();
      chk("n5_all_d1", 32'(dout3), 1);
      tick();
      chk("n5_all_d2", 32'(dout3), 2);
      clr = 1'b1; out_ready = 1'b0;
      tick();
      clr = 1'b0; out_ready = 1'b1; din3 = '0;
      chk("n5_clr_valid", 32'(vld3), 0);
      chk("n5_clr_pend", 32'(pnd3), 0);
      chk("n5_clr_dout_kept", 32'(dout3), 2);
      chk("n5_clr_ovf", 32'(ovf3), 0);
      tick();
      chk("n5_clr_stay_idle", 32'(vld3), 0);
      // pointer back at N-1 after the flush: search restarts at index 0
      din3 = 5'b01010; exp_q.push_back(1); exp_q.push_back(3);
      tick(); din3 = '0;
      tick();
      chk("n5_ptr_d1", 32'(dout3), 1);
      tick();
      chk("n5_ptr_d3", 32'(dout3), 3);
      chk("n5_range3", 32'(dout3 <= 3'd4), 1);
      tick();
      chk("n5_done", 32'(vld3), 0);
      chk("n5_sb_empty", 32'(exp_q.size()), 0);

      // asynchronous reset mid-grant
      act = 0;
      out_ready = 1'b0; din0 = 8'h06;
      tick(); din0 = '0;
      tick();
      chk("ar_valid_before", 32'(vld0), 1);
      chk("ar_pend_before", 32'(pnd0), 32'h06);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(vld0), 0);
      chk("ar_dout", 32'(dout0), 0);
      chk("ar_pend", 32'(pnd0), 0);
      chk("ar_ovf", 32'(ovf0), 0);
      chk("ar_multi", 32'(mul0), 0);
      tick();
      rst_n = 1'b1; out_ready = 1'b1;
      din0 = 8'h08; exp_q.push_back(3);
      tick(); din0 = '0;
      chk("ar_lat_t1", 32'(vld0), 0);
      tick();
      chk("ar_lat_t2", 32'(vld0), 1);
      chk("ar_lat_dout", 32'(dout0), 3);
      tick();
      chk("ar_done", 32'(vld0), 0);
      chk("ar_sb_empty", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prio_enc_q.md
# prio_enc_q

Parametrised, registered priority encoder with event capture and a valid/ready output. It generalises the team's 8:3 one-hot encoder. Input request pulses on `d_in` are latched into a pending vector. One index at a time is encoded onto `d_out` under a selectable priority mode (fixed-LSB, fixed-MSB, round-robin), and each index is held until the consumer accepts it. Multi-hot and no-hot inputs are legal: multiple requests are serialised, and no request produces no output.

## Interface
Parameters:
- `N`, 8: number of request lines; N ≥ 2, any value (power of two not required).
- `W`, `$clog2(N)`: width of `d_out`.
- `MODE`, 0: 0 = fixed priority, lowest index wins; 1 = fixed priority, highest index wins; 2 = round-robin.

Ports:
- `clk`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `d_in`, input, N: request event lines, sampled every cycle. Any number of bits may be set.
- `clr`, input, 1: synchronous flush.
- `out_ready`, input, 1: consumer accepts `d_out` this cycle.
- `d_out`, output, W: encoded index of the current grant; always ≤ N-1.
- `out_valid`, output, 1: `d_out` is valid.
- `pending`, output, N: registered pending-request vector.
- `multi`, output, 1: popcount(`pending`) > 1. Combinational from the `pending` register.
- `overflow`, output, 1: registered one-cycle pulse. Flags a request that collided with an already-pending one.

## Operation
- **Accept:** `acc` = `out_valid` & `out_ready`; `acc_vec` = one-hot(`d_out`) when `acc`, else 0.
- **Pending update:** `pending` ← (`pending` & ~`acc_vec`) | `d_in`. A `d_in` bit arriving in the accept cycle re-sets the bit being cleared, and counts as a new event.
- **Overflow:** `overflow` ← OR over i of (`d_in[i]` & `pending[i]` & ~`acc_vec[i]`).
- **Select function `sel(v)`:**
  - MODE 0: lowest set index of v.
  - MODE 1: highest set index of v.
  - MODE 2: first set index searching `ptr`+1, `ptr`+2, … with wrap modulo N.
- **Output FSM, two states:**
  - IDLE (`out_valid`=0): if `pending` ≠ 0, load `d_out` ← `sel(pending)`, set `out_valid`=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD (`out_valid`=1):
    - If !`out_ready`: `d_out` and `out_valid` are held stable. The indexed pending bit stays set.
    - On `acc` with r = `pending` & ~`acc_vec` ≠ 0: load `d_out` ← `sel(r)` and stay in HOLD. This gives back-to-back throughput of one grant per cycle.
    - On `acc` with r = 0: go to IDLE, `out_valid` ← 0.
  - Same-cycle `d_in` is not considered for the next selection; it enters through `pending` one cycle later.
- **Round-robin pointer (`ptr`):** internal, W bits. On `acc`, `ptr` ← `d_out`. Unused in MODE 0/1.
- **Clear (`clr`):** `pending`, `out_valid`, `overflow` ← 0 and `ptr` ← N-1; `d_out` keeps its value. `d_in` and `acc` in the `clr` cycle are ignored. `clr` has priority over all other updates.
- **Reset values:** `pending`=0, `d_out`=0, `out_valid`=0, `overflow`=0, `multi`=0, `ptr`=N-1 (so round-robin starts its search at index 0).

## Timing
- **Latency:** `d_in[i]` high in cycle t → `pending[i]` set at t+1 → `out_valid`=1 with `d_out`=i at t+2, provided the FSM is IDLE and i wins selection.
- **Throughput:** one grant per cycle while `out_ready`=1 and `pending` holds further bits.
- **Holding:** `d_out` must not change while `out_valid`=1 and `out_ready`=0.
- **Asynchronous reset mid-operation:** all outputs go to their reset values immediately. The first grant can appear no earlier than 2 cycles after `rst_n` rises and a request is applied.
- **Non-power-of-two N:** the round-robin wrap is modulo N, so `d_out` never encodes an index ≥ N.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant → `out_valid`=0, `d_out`=0, `pending`=0, `overflow`=0 immediately.
- **Single request, N=8, MODE 0, `out_ready`=1:** `d_in`=8'b0001_0000 for one cycle → `out_valid`=1 with `d_out`=3'd4 exactly two cycles later, for one cycle; then `pending`=0.
- **Multi-hot, MODE 0, `out_ready`=1:** `d_in`=8'b1000_0101 for one cycle → `d_out`=0, 2, 7 on consecutive cycles. `multi`=1 while ≥2 bits are pending.
- **Backpressure, MODE 1:** `d_in`=8'b0100_0010, `out_ready`=0 for 5 cycles → `d_out`=6 held stable. Re-pulse `d_in[6]` → `overflow` pulses once. Then `out_ready`=1 → `d_out`=6, then 1.
- **Round-robin, MODE 2:** `d_in`=8'hFF held continuously, `out_ready`=1 → `d_out` sequence 0, 1, …, 7, 0, 1. `overflow` pulses every cycle after the first.
- **Non-power-of-two and flush, N=5, MODE 2:** `d_in`=5'b10001 → `d_out`=0, then 4. Then `d_in`=5'b11111 with `clr` asserted mid-sequence → `out_valid`=0 next cycle, `pending`=0, and no `d_out` value ever exceeds 4.
